serial_comp_arbiter: RTL

Two-requester arbiter and sequencer for the shared bit-serial comparator (`Comp_seq`). It accepts parallel BIT_LEN-bit operand pairs from two clients over valid/ready handshakes and grants them round-robin. For each granted request it clears the comparator, shifts both operands in MSB-first, and returns the greater/equal verdict over a valid/ready response channel. It sits between the parallel-word clients and the single serial comparator instance, so the serial compare resource is time-shared.

---
 rtl/serial_comp_arbiter.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/serial_comp_arbiter.sv
// serial_comp_arbiter: round-robin arbiter and sequencer that time-shares one
// bit-serial comparator between two parallel-word clients.
//
// Ports:
//   clk, reset                      clock, synchronous active-high reset
//   req{0,1}_valid/_ready/_a/_b     client request handshakes and operands
//   rsp_valid/_ready/_id/_gt/_eq    response handshake and verdict
//   busy                            high whenever not idle
//   cmp_reset, cmp_a, cmp_b         drive to the serial comparator
//   cmp_lgn, cmp_e                  verdict from the serial comparator
module serial_comp_arbiter #(
    parameter int unsigned BIT_LEN = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               req0_valid,
    output logic               req0_ready,
    input  logic [BIT_LEN-1:0] req0_a,
    input  logic [BIT_LEN-1:0] req0_b,
    input  logic               req1_valid,
    output logic               req1_ready,
    input  logic [BIT_LEN-1:0] req1_a,
    input  logic [BIT_LEN-1:0] req1_b,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic               rsp_id,
    output logic               rsp_gt,
    output logic               rsp_eq,
    output logic               busy,
    output logic               cmp_reset,
    output logic               cmp_a,
    output logic               cmp_b,
    input  logic               cmp_lgn,
    input  logic               cmp_e
);

    localparam int unsigned CNT_W = (BIT_LEN > 1) ? $clog2(BIT_LEN) : 1;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        SHIFT,
        SAMPLE,
        RESP
    } state_t;

    state_t             state, state_d;
    logic               last, last_d;
    logic               cur_id, cur_id_d;
    logic [BIT_LEN-1:0] sh_a, sh_a_d;
    logic [BIT_LEN-1:0] sh_b, sh_b_d;
    logic [CNT_W-1:0]   bitcnt, bitcnt_d;
    logic               rsp_valid_d, rsp_id_d, rsp_gt_d, rsp_eq_d;
    logic               grant0, grant1;

    // Round-robin: a lone requester wins; on contention the one not served last wins.
    assign grant0 = req0_valid & (~req1_valid | last);
    assign grant1 = req1_valid & (~req0_valid | ~last);

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    // Datapath and response registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            last      <= 1'b1;
            cur_id    <= 1'b0;
            sh_a      <= '0;
            sh_b      <= '0;
            bitcnt    <= '0;
            rsp_valid <= 1'b0;
            rsp_id    <= 1'b0;
            rsp_gt    <= 1'b0;
            rsp_eq    <= 1'b0;
        end else begin
            last      <= last_d;
            cur_id    <= cur_id_d;
            sh_a      <= sh_a_d;
            sh_b      <= sh_b_d;
            bitcnt    <= bitcnt_d;
            rsp_valid <= rsp_valid_d;
            rsp_id    <= rsp_id_d;
            rsp_gt    <= rsp_gt_d;
            rsp_eq    <= rsp_eq_d;
        end
    end

    // Next-state and output decode.
    always_comb begin
        state_d     = state;
        last_d      = last;
        cur_id_d    = cur_id;
        sh_a_d      = sh_a;
        sh_b_d      = sh_b;
        bitcnt_d    = bitcnt;
        rsp_valid_d = rsp_valid;
        rsp_id_d    = rsp_id;
        rsp_gt_d    = rsp_gt;
        rsp_eq_d    = rsp_eq;
        req0_ready  = 1'b0;
        req1_ready  = 1'b0;
        cmp_reset   = reset;
        cmp_a       = 1'b0;
        cmp_b       = 1'b0;
        busy        = (state != IDLE);

        unique case (state)
            IDLE: begin
                // No accept is offered while reset is held.
                req0_ready = grant0 & ~reset;
                req1_ready = grant1 & ~reset;
                if (grant0) begin
                    sh_a_d   = req0_a;
                    sh_b_d   = req0_b;
                    cur_id_d = 1'b0;
                    last_d   = 1'b0;
                    state_d  = CLEAR;
                end else if (grant1) begin
                    sh_a_d   = req1_a;
                    sh_b_d   = req1_b;
                    cur_id_d = 1'b1;
                    last_d   = 1'b1;
                    state_d  = CLEAR;
                end
            end
            CLEAR: begin
                cmp_reset = 1'b1;
                bitcnt_d  = CNT_W'(BIT_LEN - 1);
                state_d   = SHIFT;
            end
            SHIFT: begin
                cmp_a  = sh_a[BIT_LEN-1];
                cmp_b  = sh_b[BIT_LEN-1];
                sh_a_d = sh_a << 1;
                sh_b_d = sh_b << 1;
                if (bitcnt == '0) begin
                    state_d = SAMPLE;
                end else begin
                    bitcnt_d = bitcnt - CNT_W'(1);
                end
            end
            SAMPLE: begin
                // Comparator outputs now reflect every shifted bit.
                rsp_gt_d    = cmp_lgn & ~cmp_e;
                rsp_eq_d    = cmp_e;
                rsp_id_d    = cur_id;
                rsp_valid_d = 1'b1;
                state_d     = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule
